// File: rtl/cmp_sched.sv
// Round-robin arbiter and sequencer for a 4-bit magnitude-compare slice, MSB slice first.
// Latency: gnt one cycle after the sampling edge; done s+1 cycles after gnt (s = slices evaluated).
// Backpressure: one compare in flight; requests seen while busy wait for the next IDLE cycle.
module cmp_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WIDTH-1:0]    num1,
    input  logic [NREQ*WIDTH-1:0]    num2,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(NREQ)-1:0]  done_id,
    output logic [3:0]               out,
    output logic                     cout
);

    localparam int IW = $clog2(NREQ);
    localparam int NS = WIDTH / 4;
    localparam int KW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q;
    logic [IW-1:0]      id_q;
    logic [KW-1:0]      k_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               gt_q, lt_q, eq_q;

    logic               win_vld;
    logic [IW-1:0]      win_id;
    logic [3:0]         a_sl, b_sl;
    logic               gt_n, lt_n, eq_n;
    logic               load, step, finish;

    // Lowest rotated offset from ptr wins, so scan offsets downward and let later hits override.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_id  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (req[idx]) begin
                win_vld = 1'b1;
                win_id  = IW'(idx);
            end
        end
    end

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < NS; i++) begin
            if (k_q == KW'(i)) begin
                a_sl = a_q[4*i +: 4];
                b_sl = b_q[4*i +: 4];
            end
        end
    end

    assign gt_n = gt_q | (eq_q & (a_sl > b_sl));
    assign lt_n = lt_q | (eq_q & (a_sl < b_sl));
    assign eq_n = eq_q & (a_sl == b_sl);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (gt_n || lt_n || (k_q == '0)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                finish  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            id_q    <= '0;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b1;
            gnt     <= '0;
            done    <= 1'b0;
            done_id <= '0;
            out     <= 4'b0000;
        end else begin
            gnt  <= '0;
            done <= finish;
            if (load) begin
                gnt   <= NREQ'(1) << win_id;
                ptr_q <= (win_id == IW'(NREQ - 1)) ? '0 : win_id + 1'b1;
                id_q  <= win_id;
                a_q   <= num1[win_id*WIDTH +: WIDTH];
                b_q   <= num2[win_id*WIDTH +: WIDTH];
                gt_q  <= 1'b0;
                lt_q  <= 1'b0;
                eq_q  <= 1'b1;
                k_q   <= KW'(NS - 1);
            end
            if (step) begin
                gt_q <= gt_n;
                lt_q <= lt_n;
                eq_q <= eq_n;
                if (!(gt_n || lt_n || (k_q == '0))) begin
                    k_q <= k_q - 1'b1;
                end
            end
            if (finish) begin
                out     <= {1'b0, gt_q, lt_q, eq_q};
                done_id <= id_q;
            end
        end
    end

    assign busy = (state_q != S_IDLE);
    assign cout = 1'b0;

endmodule
